// File: rtl/qkv_fetch_pkg.sv
// Shared definitions for the Q/K/V fetch arbiter: FSM state encoding,
// default Buffer_Select width and a width helper for the round-robin pointer.
package qkv_fetch_pkg;

    // Arbiter FSM states; encoding is fixed so it can be observed on a debug bus.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEFAULT_SEL_W = 3;

    // Number of bits needed to index n entries; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/qkv_fetch_arbiter_rr_pick.sv
// Combinational round-robin selector: scans the request vector starting one
// position after the pointer (wrapping at NUM_REQ) and returns the first
// requester found, both as a one-hot vector and as an index.
module rr_pick
    import qkv_fetch_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [PTR_W-1:0]   pick_idx,
    output logic               pick_valid
);

    int cand_idx;

    // Walk the candidates in priority order; the first active one wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        pick_onehot = '0;
        pick_idx    = '0;
        pick_valid  = 1'b0;
        cand_idx    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_idx = (int'(ptr) + off) % NUM_REQ;
            if (!pick_valid && req[cand_idx]) begin
                pick_valid            = 1'b1;
                pick_idx              = PTR_W'(cand_idx);
                pick_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qkv_fetch_arbiter.sv
// Q/K/V fetch arbiter: shares the single buffer fetch engine among NUM_REQ
// tile schedulers. A round-robin winner has its Buffer_Select, Tiles_Control
// and address-reset request latched, the fetch is started with a one-cycle
// pulse, and the requester receives a one-cycle done once fetch_done arrives.
// Optional watchdog: define QKV_FETCH_TIMEOUT_EN to abort a fetch that does
// not finish within TIMEOUT_CYCLES cycles and raise a sticky timeout_err.
module qkv_fetch_arbiter
    import qkv_fetch_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int SEL_W          = DEFAULT_SEL_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SEL_W-1:0] req_buf_sel,
    input  logic [NUM_REQ-1:0]       req_tiles_ctrl,
    input  logic [NUM_REQ-1:0]       req_rst_addr,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     start_fetch,
    output logic                     reset_addr_counter,
    output logic [SEL_W-1:0]         Buffer_Select,
    output logic                     Tiles_Control,
    input  logic                     fetch_done,
    input  logic                     busy,
    output logic                     arb_busy,
    output logic                     timeout_err
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // FSM and latched transaction fields
    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               tiles_q, tiles_d;
    logic               rst_addr_q, rst_addr_d;

    // Registered outputs
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               start_fetch_q, start_fetch_d;
    logic               reset_addr_counter_q, reset_addr_counter_d;
    logic [SEL_W-1:0]   buffer_select_q, buffer_select_d;
    logic               tiles_control_q, tiles_control_d;
    logic               arb_busy_q, arb_busy_d;

    // Round-robin selection results
    logic [NUM_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    // Watchdog expiry this cycle (always 0 when the watchdog is not built)
    logic               timeout_hit;

    // busy is observed by the fetch logic's owner only; it never gates the FSM.
    logic               unused_busy;
    assign unused_busy = busy;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req         (req),
        .ptr         (ptr_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

`ifdef QKV_FETCH_TIMEOUT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    // Watchdog: cleared while issuing, counts every WAIT cycle, error is sticky.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        timeout_hit   = 1'b0;
        if (state_q == ST_ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_d  = wait_cnt_q + 32'd1;
            timeout_hit = !fetch_done && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
        end
        timeout_err_d = timeout_err_q | timeout_hit;
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // State register, latched transaction fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q              <= ST_IDLE;
            ptr_q                <= PTR_RESET;
            sel_q                <= '0;
            tiles_q              <= 1'b0;
            rst_addr_q           <= 1'b0;
            gnt_q                <= '0;
            done_q               <= '0;
            start_fetch_q        <= 1'b0;
            reset_addr_counter_q <= 1'b0;
            buffer_select_q      <= '0;
            tiles_control_q      <= 1'b0;
            arb_busy_q           <= 1'b0;
        end else begin
            state_q              <= state_d;
            ptr_q                <= ptr_d;
            sel_q                <= sel_d;
            tiles_q              <= tiles_d;
            rst_addr_q           <= rst_addr_d;
            gnt_q                <= gnt_d;
            done_q               <= done_d;
            start_fetch_q        <= start_fetch_d;
            reset_addr_counter_q <= reset_addr_counter_d;
            buffer_select_q      <= buffer_select_d;
            tiles_control_q      <= tiles_control_d;
            arb_busy_q           <= arb_busy_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, latch the winner's fields, track the fetch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        tiles_d    = tiles_q;
        rst_addr_d = rst_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_ISSUE;
                    ptr_d      = pick_idx;
                    sel_d      = req_buf_sel[int'(pick_idx)*SEL_W +: SEL_W];
                    tiles_d    = req_tiles_ctrl[pick_idx];
                    rst_addr_d = req_rst_addr[pick_idx];
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fetch_done || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: outputs are registered, so they are decoded from the next state.
    always_comb begin
        gnt_d                = '0;
        done_d               = '0;
        start_fetch_d        = 1'b0;
        reset_addr_counter_d = 1'b0;
        buffer_select_d      = '0;
        tiles_control_d      = 1'b0;
        arb_busy_d           = 1'b0;
        if (state_d != ST_IDLE) begin
            gnt_d           = ONE_HOT_0 << ptr_d;
            buffer_select_d = sel_d;
            tiles_control_d = tiles_d;
            arb_busy_d      = 1'b1;
        end
        if (state_d == ST_ISSUE) begin
            start_fetch_d        = 1'b1;
            reset_addr_counter_d = rst_addr_d;
        end
        if (state_d == ST_DONE) begin
            done_d = ONE_HOT_0 << ptr_d;
        end
    end

    assign gnt                = gnt_q;
    assign done               = done_q;
    assign start_fetch        = start_fetch_q;
    assign reset_addr_counter = reset_addr_counter_q;
    assign Buffer_Select      = buffer_select_q;
    assign Tiles_Control      = tiles_control_q;
    assign arb_busy           = arb_busy_q;

endmodule

// File: tb/tb_qkv_fetch_arbiter.sv
// Directed testbench for qkv_fetch_arbiter (NUM_REQ=3, SEL_W=3, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_qkv_fetch_arbiter;

    localparam int NUM_REQ = 3;
    localparam int SEL_W   = 3;
    localparam int TMO     = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*SEL_W-1:0] req_buf_sel;
    logic [NUM_REQ-1:0]       req_tiles_ctrl;
    logic [NUM_REQ-1:0]       req_rst_addr;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     start_fetch;
    logic                     reset_addr_counter;
    logic [SEL_W-1:0]         Buffer_Select;
    logic                     Tiles_Control;
    logic                     fetch_done;
    logic                     busy;
    logic                     arb_busy;
    logic                     timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    qkv_fetch_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .SEL_W          (SEL_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_buf_sel        (req_buf_sel),
        .req_tiles_ctrl     (req_tiles_ctrl),
        .req_rst_addr       (req_rst_addr),
        .gnt                (gnt),
        .done               (done),
        .start_fetch        (start_fetch),
        .reset_addr_counter (reset_addr_counter),
        .Buffer_Select      (Buffer_Select),
        .Tiles_Control      (Tiles_Control),
        .fetch_done         (fetch_done),
        .busy               (busy),
        .arb_busy           (arb_busy),
        .timeout_err        (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_start"}, 32'(start_fetch), 32'd0);
        check({tag, "_rac"},   32'(reset_addr_counter), 32'd0);
        check({tag, "_bsel"},  32'(Buffer_Select), 32'd0);
        check({tag, "_tiles"}, 32'(Tiles_Control), 32'd0);
        check({tag, "_abusy"}, 32'(arb_busy), 32'd0);
        check({tag, "_tmo"},   32'(timeout_err), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    task automatic pulse_fetch_done();
        fetch_done = 1'b1;
        tick();
        fetch_done = 1'b0;
    endtask

    // Bounded wait for start_fetch; an expired bound shows up as a failed comparison.
    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (start_fetch !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_start_seen"}, 32'(start_fetch), 32'd1);
    endtask

    // One complete transaction for requester g: grant, wait wcyc cycles, finish.
    task automatic run_txn(input string tag, input int g, input int wcyc, input logic [NUM_REQ-1:0] clr);
        logic [NUM_REQ-1:0] oh;
        int extra;
        oh = 3'b001 << g;
        extra = 0;
        wait_start(tag);
        check({tag, "_gnt_issue"}, 32'(gnt), 32'(oh));
        tick();
        repeat (wcyc) begin
            if (start_fetch !== 1'b0 || done !== '0) extra++;
            tick();
        end
        check({tag, "_no_extra_pulse"}, 32'(extra), 32'd0);
        pulse_fetch_done();
        check({tag, "_done"}, 32'(done), 32'(oh));
        check({tag, "_gnt_done"}, 32'(gnt), 32'(oh));
        req = req & ~clr;
        tick();
        check({tag, "_done_clear"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(arb_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int extra;
        rst            = 1'b1;
        req            = '0;
        req_buf_sel    = '0;
        req_tiles_ctrl = '0;
        req_rst_addr   = '0;
        fetch_done     = 1'b0;
        busy           = 1'b0;

        // ---- Test 1: single request from requester 1 ----
        do_reset();
        req            = 3'b010;
        req_buf_sel    = {3'b111, 3'b010, 3'b101};
        req_tiles_ctrl = 3'b010;
        req_rst_addr   = 3'b010;
        tick();
        check("t1_gnt",   32'(gnt), 32'b010);
        check("t1_start", 32'(start_fetch), 32'd1);
        check("t1_rac",   32'(reset_addr_counter), 32'd1);
        check("t1_bsel",  32'(Buffer_Select), 32'd2);
        check("t1_tiles", 32'(Tiles_Control), 32'd1);
        check("t1_abusy", 32'(arb_busy), 32'd1);
        req_buf_sel    = '1;
        req_tiles_ctrl = '0;
        busy           = 1'b1;
        tick();
        check("t1_wait_start", 32'(start_fetch), 32'd0);
        check("t1_wait_rac",   32'(reset_addr_counter), 32'd0);
        check("t1_wait_gnt",   32'(gnt), 32'b010);
        check("t1_wait_bsel",  32'(Buffer_Select), 32'd2);
        check("t1_wait_tiles", 32'(Tiles_Control), 32'd1);
        repeat (19) tick();
        check("t1_pre_done", 32'(done), 32'd0);
        pulse_fetch_done();
        busy = 1'b0;
        check("t1_done",      32'(done), 32'b010);
        check("t1_done_gnt",  32'(gnt), 32'b010);
        check("t1_done_bsel", 32'(Buffer_Select), 32'd2);
        req = '0;
        tick();
        check_all_zero("t1_after");

        // ---- Test 2: all three requesting from reset, order 0,1,2,0 ----
        req_buf_sel    = {3'b011, 3'b010, 3'b001};
        req_tiles_ctrl = 3'b000;
        req_rst_addr   = 3'b000;
        rst = 1'b1;
        req = 3'b111;
        tick();
        tick();
        check_all_zero("t2_reset");
        rst = 1'b0;
        run_txn("t2_a", 0, 3, 3'b000);
        run_txn("t2_b", 1, 2, 3'b000);
        run_txn("t2_c", 2, 4, 3'b000);
        run_txn("t2_d", 0, 1, 3'b111);

        // ---- Test 3: requester 2 drops req during WAIT ----
        req = 3'b100;
        wait_start("t3");
        check("t3_gnt", 32'(gnt), 32'b100);
        check("t3_bsel", 32'(Buffer_Select), 32'd3);
        tick();
        req = 3'b000;
        repeat (3) tick();
        check("t3_still_gnt", 32'(gnt), 32'b100);
        pulse_fetch_done();
        check("t3_done", 32'(done), 32'b100);
        extra = 0;
        repeat (6) begin
            tick();
            if (start_fetch !== 1'b0 || gnt !== '0) extra++;
        end
        check("t3_no_regrant", 32'(extra), 32'd0);

        // ---- Test 4: stray fetch_done in IDLE and in ISSUE ----
        pulse_fetch_done();
        check("t4_idle_done",  32'(done), 32'd0);
        check("t4_idle_abusy", 32'(arb_busy), 32'd0);
        req = 3'b001;
        tick();
        check("t4_issue_start", 32'(start_fetch), 32'd1);
        check("t4_issue_gnt",   32'(gnt), 32'b001);
        pulse_fetch_done();
        check("t4_wait_done",  32'(done), 32'd0);
        check("t4_wait_abusy", 32'(arb_busy), 32'd1);
        check("t4_wait_start", 32'(start_fetch), 32'd0);
        tick();
        tick();
        check("t4_wait2_done", 32'(done), 32'd0);
        check("t4_wait2_gnt",  32'(gnt), 32'b001);
        pulse_fetch_done();
        check("t4_done", 32'(done), 32'b001);
        req = 3'b000;
        tick();
        check("t4_idle_after", 32'(arb_busy), 32'd0);

        // ---- Test 5: reset during WAIT, pointer returns to favour requester 0 ----
        req = 3'b010;
        tick();
        check("t5_issue_gnt", 32'(gnt), 32'b010);
        tick();
        tick();
        check("t5_wait_abusy", 32'(arb_busy), 32'd1);
        rst = 1'b1;
        req = 3'b000;
        tick();
        check_all_zero("t5_rst");
        rst = 1'b0;
        req = 3'b101;
        tick();
        check("t5_regrant", 32'(gnt), 32'b001);
        check("t5_start",   32'(start_fetch), 32'd1);
        tick();
        pulse_fetch_done();
        check("t5_done", 32'(done), 32'b001);
        req = 3'b000;
        tick();
        check("t5_idle", 32'(arb_busy), 32'd0);

        // ---- Test 6: fetch_done withheld ----
        req = 3'b010;
        tick();
        check("t6_start", 32'(start_fetch), 32'd1);
`ifdef QKV_FETCH_TIMEOUT_EN
        repeat (TMO) tick();
        check("t6_pre_done", 32'(done), 32'd0);
        check("t6_pre_tmo",  32'(timeout_err), 32'd0);
        tick();
        check("t6_tmo_done", 32'(done), 32'b010);
        check("t6_tmo_err",  32'(timeout_err), 32'd1);
        req = 3'b000;
        tick();
        check("t6_idle",        32'(arb_busy), 32'd0);
        check("t6_tmo_sticky",  32'(timeout_err), 32'd1);
        req = 3'b001;
        run_txn("t6_next", 0, 2, 3'b001);
        check("t6_tmo_sticky2", 32'(timeout_err), 32'd1);
`else
        repeat (30) tick();
        check("t6_hold_done",  32'(done), 32'd0);
        check("t6_hold_abusy", 32'(arb_busy), 32'd1);
        check("t6_hold_gnt",   32'(gnt), 32'b010);
        check("t6_hold_tmo",   32'(timeout_err), 32'd0);
        pulse_fetch_done();
        check("t6_done", 32'(done), 32'b010);
        req = 3'b000;
        tick();
        check("t6_idle", 32'(arb_busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
